clause_status_streamer: RTL and testbench
=========================================

Name: clause_status_streamer

Overview:
Sequential producer that feeds clause status pairs (clause index, satisfied flag) to the unsatisfied-clause selection logic of the MCMC solver, one pair per handshake.
- On a start pulse it snapshots the clause-satisfaction vector and a start offset.
- It streams every clause exactly once, beginning at the offset and wrapping, so downstream first-unsatisfied selection becomes a random choice.
- At the end it reports the number of unsatisfied clauses.

Parameters:
NUMBER_OF_CLAUSES, 2, clauses streamed per run (>=2).
MAXIMUM_BIT_WIDTH_OF_CLAUSES_INDEX, 1, clause index width; 2^width >= NUMBER_OF_CLAUSES.

Ports:
in_clk  input  1  clock, all logic on rising edge.
in_reset  input  1  asynchronous, active-high reset.
in_start  input  1  one-cycle start request; honoured only in IDLE.
in_clauses_satisfied  input  NUMBER_OF_CLAUSES  bit i = clause i satisfied; sampled on accepted start.
in_start_offset  input  MAXIMUM_BIT_WIDTH_OF_CLAUSES_INDEX  first index to emit (from LFSR); sampled on accepted start.
in_ready  input  1  downstream accepts current pair.
out_valid  output  1  pair on out_clause_index/out_clause_satisfied is valid.
out_clause_index  output  MAXIMUM_BIT_WIDTH_OF_CLAUSES_INDEX  current clause index.
out_clause_satisfied  output  1  satisfied flag of current clause.
out_last  output  1  current pair is the final one of the run.
out_busy  output  1  high in STREAM and DONE.
out_done  output  1  one-cycle pulse after final handshake.
out_unsatisfied_count  output  MAXIMUM_BIT_WIDTH_OF_CLAUSES_INDEX+1  unsatisfied clauses in the run; valid with out_done, held until next accepted start.

Behaviour:
- Reset (async, any state): state IDLE; all outputs 0; snapshot, index and counters cleared. An in-flight run is discarded with no done pulse.
- States: IDLE, STREAM, DONE.
- IDLE:
  - in_start=1: latch in_clauses_satisfied.
  - Latch offset: in_start_offset if < NUMBER_OF_CLAUSES, else 0.
  - Clear emitted and unsatisfied counters, go to STREAM.
  - out_valid rises the cycle after start (latency 1).
- STREAM:
  - out_valid=1; out_clause_index = current index; out_clause_satisfied = snapshot[current index].
  - out_last=1 when emitted count = NUMBER_OF_CLAUSES-1.
  - Handshake = out_valid & in_ready.
  - On handshake: unsatisfied counter += !out_clause_satisfied; emitted += 1; index += 1, wrapping NUMBER_OF_CLAUSES-1 -> 0 (explicit compare, not power-of-2 overflow).
  - On handshake with out_last=1: go to DONE; out_valid drops next cycle.
  - Without handshake, all stream outputs hold stable (no glitch, no advance).
- DONE (exactly one cycle): out_done=1, out_unsatisfied_count = final count (including final pair), out_valid=0. Then IDLE.
- in_start while busy: ignored, no queueing. in_start in the DONE cycle: ignored.
- in_ready while out_valid=0: no effect.
- Changes to in_clauses_satisfied during a run: no effect on the run.
- Each run emits every index 0..N-1 exactly once. Minimum run length is N+2 cycles from start to done when in_ready is constantly 1.
- All-satisfied run: count 0. All-unsatisfied run: count N (needs the extra width bit).

Test Plan:
- N=2,W=1 defaults; start, vector=2'b10, offset=0, ready=1 -> valid cycle after start: (0,sat 0), then (1,sat 1,last); done pulse next cycle with count=1.
- N=4,W=2; vector=4'b0101, offset=2, ready=1 -> indices 2,3,0,1 with sat 1,0,1,0; last on index 1; count=2.
- N=3,W=2; offset=3 (out of range) -> stream starts at 0: 0,1,2; wrap from 2 never emits 3.
- N=4; ready toggled 1,0,0,1,... -> pairs hold stable while ready=0; exactly 4 handshakes; done after the 4th.
- N=4; vector=4'b0000 -> count=4. Vector=4'b1111 -> count=0. Start asserted mid-stream is ignored; the run completes unchanged.
- N=4; assert reset after 2 handshakes -> outputs 0 immediately (async), no done pulse; a new start runs a full clean stream.

Source files
------------

// File: rtl/clause_status_streamer.sv
// clause_status_streamer: streams a snapshot of clause satisfaction flags, one pair per handshake,
// starting at a random offset and wrapping, then reports the unsatisfied count.
module clause_status_streamer #(
    parameter int NUMBER_OF_CLAUSES = 2,
    parameter int MAXIMUM_BIT_WIDTH_OF_CLAUSES_INDEX = 1
) (
    input  logic                                          in_clk,
    input  logic                                          in_reset,
    input  logic                                          in_start,
    input  logic [NUMBER_OF_CLAUSES-1:0]                  in_clauses_satisfied,
    input  logic [MAXIMUM_BIT_WIDTH_OF_CLAUSES_INDEX-1:0] in_start_offset,
    input  logic                                          in_ready,
    output logic                                          out_valid,
    output logic [MAXIMUM_BIT_WIDTH_OF_CLAUSES_INDEX-1:0] out_clause_index,
    output logic                                          out_clause_satisfied,
    output logic                                          out_last,
    output logic                                          out_busy,
    output logic                                          out_done,
    output logic [MAXIMUM_BIT_WIDTH_OF_CLAUSES_INDEX:0]   out_unsatisfied_count
);
    localparam int N = NUMBER_OF_CLAUSES;
    localparam int W = MAXIMUM_BIT_WIDTH_OF_CLAUSES_INDEX;
    localparam logic [W:0] N_W = (W+1)'(N);
    localparam logic [W:0] LAST_CNT = N_W - 1'b1;
    localparam logic [W-1:0] LAST_IDX = W'(N - 1);

    typedef enum logic [1:0] {IDLE, STREAM, DONE} state_t;

    state_t         state_q, state_d;
    logic [N-1:0]   snap_q, snap_d;
    logic [W-1:0]   idx_q, idx_d;
    logic [W:0]     emitted_q, emitted_d;
    logic [W:0]     unsat_q, unsat_d;
    logic           hs;

    assign out_valid             = (state_q == STREAM);
    assign out_busy              = (state_q != IDLE);
    assign out_done              = (state_q == DONE);
    assign out_clause_index      = idx_q;
    assign out_clause_satisfied  = snap_q[idx_q];
    assign out_last              = out_valid && (emitted_q == LAST_CNT);
    assign out_unsatisfied_count = unsat_q;
    assign hs                    = out_valid & in_ready;

    always_comb begin
        state_d   = state_q;
        snap_d    = snap_q;
        idx_d     = idx_q;
        emitted_d = emitted_q;
        unsat_d   = unsat_q;
        case (state_q)
            IDLE: if (in_start) begin
                state_d   = STREAM;
                snap_d    = in_clauses_satisfied;
                idx_d     = ({1'b0, in_start_offset} < N_W) ? in_start_offset : '0;
                emitted_d = '0;
                unsat_d   = '0;
            end
            STREAM: if (hs) begin
                unsat_d   = unsat_q + {{W{1'b0}}, ~out_clause_satisfied};
                emitted_d = emitted_q + 1'b1;
                // explicit wrap so non-power-of-two clause counts never emit an out-of-range index
                idx_d     = (idx_q == LAST_IDX) ? '0 : idx_q + 1'b1;
                state_d   = out_last ? DONE : STREAM;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge in_clk or posedge in_reset) begin
        if (in_reset) begin
            state_q   <= IDLE;
            snap_q    <= '0;
            idx_q     <= '0;
            emitted_q <= '0;
            unsat_q   <= '0;
        end else begin
            state_q   <= state_d;
            snap_q    <= snap_d;
            idx_q     <= idx_d;
            emitted_q <= emitted_d;
            unsat_q   <= unsat_d;
        end
    end
endmodule

// File: tb/tb_clause_status_streamer.sv
// tb_clause_status_streamer: directed checks on a 4-clause and a 3-clause streamer.
module tb_clause_status_streamer;
    logic       clk = 0;
    logic       rst = 1;
    logic       start = 0, ready = 0;
    logic [3:0] sat = '0;
    logic [1:0] offs = '0;
    logic       valid, last, csat, busy, done;
    logic [1:0] idx;
    logic [2:0] cnt;
    logic       start3 = 0, ready3 = 0;
    logic [2:0] sat3 = '0;
    logic [1:0] offs3 = '0;
    logic       valid3, last3, csat3, busy3, done3;
    logic [1:0] idx3;
    logic [2:0] cnt3;
    int checks = 0, errors = 0;

    always #5 clk = ~clk;

    clause_status_streamer #(.NUMBER_OF_CLAUSES(4), .MAXIMUM_BIT_WIDTH_OF_CLAUSES_INDEX(2)) u4 (
        .in_clk(clk), .in_reset(rst), .in_start(start), .in_clauses_satisfied(sat),
        .in_start_offset(offs), .in_ready(ready), .out_valid(valid), .out_clause_index(idx),
        .out_clause_satisfied(csat), .out_last(last), .out_busy(busy), .out_done(done),
        .out_unsatisfied_count(cnt));

    clause_status_streamer #(.NUMBER_OF_CLAUSES(3), .MAXIMUM_BIT_WIDTH_OF_CLAUSES_INDEX(2)) u3 (
        .in_clk(clk), .in_reset(rst), .in_start(start3), .in_clauses_satisfied(sat3),
        .in_start_offset(offs3), .in_ready(ready3), .out_valid(valid3), .out_clause_index(idx3),
        .out_clause_satisfied(csat3), .out_last(last3), .out_busy(busy3), .out_done(done3),
        .out_unsatisfied_count(cnt3));

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    // rpat bit c is in_ready for stream cycle c; mid asserts a stray start during the run and in DONE
    task automatic run4(input string nm, input logic [3:0] vec, input logic [1:0] off,
                        input logic [15:0] rpat, input logic mid, input int exp_cnt);
        int k, c;
        logic [1:0] ei;
        @(negedge clk);
        start = 1; sat = vec; offs = off; ready = 0;
        @(negedge clk);
        start = 0; sat = ~vec; offs = off + 2'd1;
        chk({nm, "_valid_lat1"}, valid, 1);
        chk({nm, "_busy"}, busy, 1);
        k = 0; c = 0;
        while (k < 4 && c < 40) begin
            ready = rpat[c % 16];
            start = mid && (c == 1);
            ei = off + k[1:0];
            chk({nm, "_valid"}, valid, 1);
            chk({nm, "_idx"}, idx, ei);
            chk({nm, "_sat"}, csat, vec[ei]);
            chk({nm, "_last"}, last, k == 3);
            chk({nm, "_nodone"}, done, 0);
            if (ready) k++;
            c++;
            @(negedge clk);
        end
        ready = 0; start = 0;
        chk({nm, "_handshakes"}, k, 4);
        chk({nm, "_done"}, done, 1);
        chk({nm, "_done_novalid"}, valid, 0);
        chk({nm, "_count"}, cnt, exp_cnt);
        start = mid;
        @(negedge clk);
        start = 0;
        chk({nm, "_done_pulse"}, done, 0);
        chk({nm, "_idle"}, busy, 0);
        chk({nm, "_count_held"}, cnt, exp_cnt);
    endtask

    initial begin
        #2;
        chk("rst_valid", valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_idx", idx, 0);
        chk("rst_count", cnt, 0);
        @(negedge clk);
        rst = 0;
        run4("basic", 4'b0101, 2'd2, 16'hFFFF, 0, 2);
        run4("toggle", 4'b0110, 2'd3, 16'h9999, 0, 2);
        run4("allunsat", 4'b0000, 2'd1, 16'hFFFF, 0, 4);
        run4("allsat", 4'b1111, 2'd0, 16'hFFFF, 1, 0);
        // async reset mid-run discards the stream with no done pulse
        @(negedge clk);
        start = 1; sat = 4'b0011; offs = 2'd1; ready = 1;
        @(negedge clk);
        start = 0;
        repeat (2) @(negedge clk);
        chk("pre_rst_idx", idx, 3);
        #2 rst = 1;
        #1;
        chk("arst_valid", valid, 0);
        chk("arst_busy", busy, 0);
        chk("arst_idx", idx, 0);
        chk("arst_sat", csat, 0);
        chk("arst_last", last, 0);
        chk("arst_count", cnt, 0);
        repeat (3) begin
            @(negedge clk);
            chk("arst_nodone", done, 0);
        end
        rst = 0; ready = 0;
        run4("postrst", 4'b1001, 2'd1, 16'hFFFF, 0, 2);
        // out-of-range offset on the 3-clause instance starts at 0 and never emits index 3
        @(negedge clk);
        start3 = 1; sat3 = 3'b010; offs3 = 2'd3; ready3 = 1;
        @(negedge clk);
        start3 = 0;
        for (int k = 0; k < 3; k++) begin
            chk("n3_valid", valid3, 1);
            chk("n3_idx", idx3, k);
            chk("n3_sat", csat3, k == 1);
            chk("n3_last", last3, k == 2);
            @(negedge clk);
        end
        ready3 = 0;
        chk("n3_done", done3, 1);
        chk("n3_novalid", valid3, 0);
        chk("n3_count", cnt3, 2);
        @(negedge clk);
        chk("n3_idle", busy3, 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
